// File: rtl/gtpcap_pkg.sv
// Shared types and constants for the GTP capture sequencer: channel states,
// Wishbone register offsets and CTRL/STAT write-bit positions.
package gtpcap_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_K = 2'd1,
        RUN    = 2'd2
    } chan_state_t;

    localparam logic [1:0] REG_CSR = 2'd0;
    localparam logic [1:0] REG_TMO = 2'd1;
    localparam logic [1:0] REG_CNT = 2'd2;
    localparam logic [1:0] REG_MSK = 2'd3;

    localparam int unsigned ARM_LSB = 0;
    localparam int unsigned ABORT   = 8;
    localparam int unsigned CLEAR   = 9;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c + 4'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/gtpcap_chan.sv
// One capture channel: arms on a CSR write, starts the buffer on the next
// K-character, completes on a cntrl_ready rising edge or aborts on timeout.
module gtpcap_chan
    import gtpcap_pkg::*;
#(
    parameter int unsigned TMO_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             charisk,
    input  logic             ready,
    input  logic [TMO_W-1:0] timeout,
    output logic             run,
    output logic             done_pulse,
    output logic             tmo_pulse,
    output logic             waiting
);

    chan_state_t      state;
    chan_state_t      state_nxt;
    logic             ready_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic             ready_rise;
    logic             tmo_hit;

    always_comb begin
        ready_rise = ready & ~ready_q;
        tmo_hit    = (state != IDLE) && (timeout != '0) &&
                     (tmo_cnt == timeout - TMO_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort overrides everything; a completion beats a simultaneous timeout.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm) state_nxt = WAIT_K;
                WAIT_K:  if (tmo_hit) state_nxt = IDLE;
                         else if (charisk) state_nxt = RUN;
                RUN:     if (ready_rise || tmo_hit) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        run        = (state == RUN);
        waiting    = (state == WAIT_K);
        done_pulse = !abort && (state == RUN) && ready_rise;
        tmo_pulse  = !abort && tmo_hit && !((state == RUN) && ready_rise);
    end

    // tmo_cnt sits at zero while idle, so an arm always starts counting from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            ready_q <= ready;
            if (state == IDLE) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

endmodule

// File: rtl/gtp_capture_ctrl.sv
// Wishbone-controlled sequencer for the GTP capture buffers: register file,
// sticky done/timeout flags, completion counter and level IRQ.
module gtp_capture_ctrl
    import gtpcap_pkg::*;
#(
    parameter int unsigned      NCH         = 4,
    parameter int unsigned      TMO_W       = 24,
    parameter logic [TMO_W-1:0] TMO_DEFAULT = TMO_W'(24'h7A1200)
) (
    input  logic           wb_clk,
    input  logic           wb_rst,
    input  logic           wb_cyc,
    input  logic           wb_stb,
    input  logic           wb_we,
    input  logic [1:0]     wb_adr,
    input  logic [31:0]    wb_dat_i,
    output logic [31:0]    wb_dat_o,
    output logic           wb_ack,
    input  logic [NCH-1:0] gtp_charisk,
    input  logic [NCH-1:0] cntrl_ready,
    output logic [NCH-1:0] cntrl_run,
    output logic           irq
);

    logic             acc;
    logic             wr;
    logic             abort_all;
    logic             clear_flags;
    logic [NCH-1:0]   arm_v;
    logic [NCH-1:0]   done_p;
    logic [NCH-1:0]   tmo_p;
    logic [NCH-1:0]   wait_v;
    logic [NCH-1:0]   done_f;
    logic [NCH-1:0]   tmo_f;
    logic [TMO_W-1:0] timeout_r;
    logic [15:0]      capcnt;
    logic [15:0]      irq_mask;
    logic [31:0]      rd_data;
    logic [7:0]       run8, done8, tmo8, wait8, done_p8;
    logic             unused_dat;

    always_comb begin
        acc         = wb_cyc & wb_stb & ~wb_ack;
        wr          = acc & wb_we;
        abort_all   = wr && (wb_adr == REG_CSR) && wb_dat_i[ABORT];
        clear_flags = wr && (wb_adr == REG_CSR) && wb_dat_i[CLEAR];
        arm_v       = (wr && (wb_adr == REG_CSR)) ? wb_dat_i[ARM_LSB +: NCH] : '0;
        unused_dat  = ^wb_dat_i;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        gtpcap_chan #(
            .TMO_W(TMO_W)
        ) u_chan (
            .clk        (wb_clk),
            .rst        (wb_rst),
            .arm        (arm_v[i]),
            .abort      (abort_all),
            .charisk    (gtp_charisk[i]),
            .ready      (cntrl_ready[i]),
            .timeout    (timeout_r),
            .run        (cntrl_run[i]),
            .done_pulse (done_p[i]),
            .tmo_pulse  (tmo_p[i]),
            .waiting    (wait_v[i])
        );
    end

    always_comb begin
        run8    = '0;
        done8   = '0;
        tmo8    = '0;
        wait8   = '0;
        done_p8 = '0;
        run8[NCH-1:0]    = cntrl_run;
        done8[NCH-1:0]   = done_f;
        tmo8[NCH-1:0]    = tmo_f;
        wait8[NCH-1:0]   = wait_v;
        done_p8[NCH-1:0] = done_p;
        rd_data = '0;
        case (wb_adr)
            REG_CSR: rd_data = {wait8, tmo8, done8, run8};
            REG_TMO: rd_data[TMO_W-1:0] = timeout_r;
            REG_CNT: rd_data[15:0] = capcnt;
            REG_MSK: rd_data[15:0] = irq_mask;
            default: rd_data = '0;
        endcase
    end

    // A flag raised in the same cycle as a clear survives the clear.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wb_ack    <= 1'b0;
            wb_dat_o  <= '0;
            timeout_r <= TMO_DEFAULT;
            irq_mask  <= '0;
            capcnt    <= '0;
            done_f    <= '0;
            tmo_f     <= '0;
            irq       <= 1'b0;
        end else begin
            wb_ack <= acc;
            if (acc) begin
                wb_dat_o <= rd_data;
            end
            if (wr && (wb_adr == REG_TMO)) begin
                timeout_r <= wb_dat_i[TMO_W-1:0];
            end
            if (wr && (wb_adr == REG_MSK)) begin
                irq_mask <= wb_dat_i[15:0];
            end
            done_f <= (clear_flags ? '0 : done_f) | done_p;
            tmo_f  <= (clear_flags ? '0 : tmo_f) | tmo_p;
            capcnt <= capcnt + 16'(popcount8(done_p8));
            irq    <= |(done8 & irq_mask[7:0]) | |(tmo8 & irq_mask[15:8]);
        end
    end

endmodule

// File: tb/tb_gtp_capture_ctrl.sv
// Directed scoreboard bench for gtp_capture_ctrl (8 lanes): read expectations
// are queued by the stimulus and checked by a monitor on each read ack.
`timescale 1ns/1ps
module tb_gtp_capture_ctrl;

    localparam logic [1:0] A_CSR = 2'd0;
    localparam logic [1:0] A_TMO = 2'd1;
    localparam logic [1:0] A_CNT = 2'd2;
    localparam logic [1:0] A_MSK = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [1:0]  adr;
    logic [31:0] dat_i, dat_o;
    logic        ack;
    logic [7:0]  charisk, ready, run;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    gtp_capture_ctrl #(
        .NCH         (8),
        .TMO_W       (24),
        .TMO_DEFAULT (24'h7A1200)
    ) dut (
        .wb_clk      (clk),
        .wb_rst      (rst),
        .wb_cyc      (cyc),
        .wb_stb      (stb),
        .wb_we       (we),
        .wb_adr      (adr),
        .wb_dat_i    (dat_i),
        .wb_dat_o    (dat_o),
        .wb_ack      (ack),
        .gtp_charisk (charisk),
        .cntrl_ready (ready),
        .cntrl_run   (run),
        .irq         (irq)
    );

    always @(negedge clk) begin
        if (ack === 1'b1 && we === 1'b0) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read_ack: got 0x%08h, no read pending", dat_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (dat_o !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, dat_o, e.exp);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within 1 ms");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d);
        int n;
        if (ack) tick(1);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!ack && n < 8);
        n_tests++;
        if (!ack) begin
            n_fail++;
            $display("FAIL wb_ack_timeout: adr=%0d got ack=%b expected 1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, a, d);
    endtask

    task automatic wb_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        bus(1'b0, a, 32'h0);
    endtask

    // One arm/K/ready cycle on the lanes in m; K is held high by the caller.
    task automatic cap_round(input logic [7:0] m);
        wb_write(A_CSR, {24'h0, m});
        tick(1);
        ready = m;
        tick(1);
        ready = '0;
        tick(1);
    endtask

    initial begin
        cyc = 0; stb = 0; we = 0; adr = '0; dat_i = '0;
        charisk = '0; ready = '0; rst = 1'b1;
        tick(3);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat_o", dat_o, 32'h0);
        check("rst_run", {24'h0, run}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;
        tick(1);
        wb_read("rst_csr", A_CSR, 32'h0);
        wb_read("rst_tmo", A_TMO, 32'h007A1200);
        wb_read("rst_cnt", A_CNT, 32'h0);
        wb_read("rst_msk", A_MSK, 32'h0);

        // single capture on lane 0
        wb_write(A_CSR, 32'h1);
        tick(9);
        check("run0_before_k", {24'h0, run}, 32'h0);
        charisk = 8'h01;
        tick(1);
        charisk = '0;
        check("run0_after_k", {24'h0, run}, 32'h01);
        tick(3);
        check("run0_held", {24'h0, run}, 32'h01);
        ready = 8'h01;
        tick(1);
        check("run0_after_ready", {24'h0, run}, 32'h0);
        ready = '0;
        wb_read("done0_csr", A_CSR, 32'h00000100);
        wb_read("done0_cnt", A_CNT, 32'h1);

        // timeout on lane 2 with IRQ
        wb_write(A_TMO, 32'd100);
        wb_write(A_MSK, 32'h0400);
        wb_read("tmo_reg", A_TMO, 32'd100);
        wb_read("msk_reg", A_MSK, 32'h0400);
        wb_write(A_CSR, 32'h4);
        wb_read("wait2_csr", A_CSR, 32'h04000100);
        tick(97);
        check("run2_no_k", {24'h0, run}, 32'h0);
        check("irq_before_tmo", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_tmo_edge", {31'h0, irq}, 32'h0);
        tick(1);
        check("irq_tmo_set", {31'h0, irq}, 32'h1);
        wb_read("tmo2_csr", A_CSR, 32'h00040100);
        wb_write(A_CSR, 32'h200);
        check("irq_clear_edge", {31'h0, irq}, 32'h1);
        tick(1);
        check("irq_cleared", {31'h0, irq}, 32'h0);

        // four lanes; 1 and 3 complete together; lane 0 ready coincides with timeout
        wb_write(A_CSR, 32'hF);
        charisk = 8'h0F;
        tick(1);
        charisk = '0;
        check("run_all4", {24'h0, run}, 32'h0F);
        ready = 8'h0A;
        tick(1);
        check("run_after_1_3", {24'h0, run}, 32'h05);
        ready = '0;
        tick(97);
        ready = 8'h01;
        tick(1);
        check("run_after_tmo", {24'h0, run}, 32'h0);
        ready = '0;
        wb_read("multi_csr", A_CSR, 32'h00040B00);
        wb_read("multi_cnt", A_CNT, 32'h4);

        // abort beats arm in the same write
        wb_write(A_CSR, 32'h200);
        wb_write(A_CSR, 32'h3);
        charisk = 8'h03;
        tick(1);
        charisk = '0;
        check("run_0_1", {24'h0, run}, 32'h03);
        wb_write(A_CSR, 32'h103);
        check("run_after_abort", {24'h0, run}, 32'h0);
        wb_read("abort_csr", A_CSR, 32'h0);
        wb_read("abort_cnt", A_CNT, 32'h4);
        charisk = 8'h03;
        tick(1);
        charisk = '0;
        check("no_rearm_after_abort", {24'h0, run}, 32'h0);

        // ready high before arm, K coincident with arm ignored
        ready = 8'h01;
        tick(2);
        charisk = 8'h01;
        wb_write(A_CSR, 32'h1);
        charisk = '0;
        tick(3);
        check("k_with_arm_ignored", {24'h0, run}, 32'h0);
        charisk = 8'h01;
        tick(1);
        charisk = '0;
        check("run_ready_held", {24'h0, run}, 32'h01);
        tick(5);
        check("no_completion_ready_held", {24'h0, run}, 32'h01);
        wb_write(A_CSR, 32'h100);
        ready = '0;
        wb_read("held_csr", A_CSR, 32'h0);
        wb_read("held_cnt", A_CNT, 32'h4);

        // reset mid-RUN
        wb_write(A_CSR, 32'h1);
        charisk = 8'h01;
        tick(1);
        charisk = '0;
        check("run_before_rst", {24'h0, run}, 32'h01);
        rst = 1'b1;
        tick(1);
        check("run_after_rst", {24'h0, run}, 32'h0);
        rst = 1'b0;
        tick(1);
        wb_read("rst2_csr", A_CSR, 32'h0);
        wb_read("rst2_tmo", A_TMO, 32'h007A1200);
        wb_read("rst2_cnt", A_CNT, 32'h0);
        wb_read("rst2_msk", A_MSK, 32'h0);

        // CAPCNT wrap: 8191*8 + 6 = 0xFFFE
        charisk = 8'hFF;
        for (int r = 0; r < 8191; r++) cap_round(8'hFF);
        cap_round(8'h3F);
        wb_read("cnt_fffe", A_CNT, 32'h0000FFFE);
        cap_round(8'h01);
        wb_read("cnt_ffff", A_CNT, 32'h0000FFFF);
        cap_round(8'h01);
        wb_read("cnt_wrap", A_CNT, 32'h0);
        cap_round(8'h07);
        wb_read("cnt_after_wrap", A_CNT, 32'h3);
        charisk = '0;

        tick(3);
        check("scoreboard_drained", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
